// File: rtl/otter_fetch_pkg.sv
// otter_fetch_pkg: shared types and constants for the Otter instruction fetch unit.
package otter_fetch_pkg;

    typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} fetch_state_t;

    localparam logic [31:0] ILEN      = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer toward decode; flush discards contents and wins over push/pop.
module fetch_fifo
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [AW:0]  count,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {AW'(0), do_push} - {AW'(0), do_pop};
        end
    end

    // Issue gating upstream must keep a net push out of a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && count == (AW + 1)'(DEPTH)));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: one-at-a-time instruction fetch controller with PC update, redirect
// handling and a small decode-side buffer.
module instr_fetch
    import otter_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC_COUNT,
    output logic        PC_WE,
    output logic [31:0] PC_DIN,
    output logic        MEM_RDEN,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    input  logic        REDIR_VALID,
    input  logic [31:0] REDIR_ADDR,
    output logic        IR_VALID,
    input  logic        IR_READY,
    output logic [31:0] IR_DATA,
    output logic [31:0] IR_PC
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state, state_n;
    fetch_entry_t  head, entry;
    logic [31:0]   tag;
    logic [CW-1:0] count;
    logic [CW:0]   fill;
    logic          outstanding, issue, push, empty;

    assign outstanding = state != ISSUE;
    assign fill        = {1'b0, count} + {{CW{1'b0}}, outstanding};
    // Gating on RST_N keeps every request/write output low while reset is held.
    assign issue       = RST_N && state == ISSUE && !REDIR_VALID && fill < (CW + 1)'(FIFO_DEPTH);
    assign push        = state == WAIT && MEM_RVALID && !REDIR_VALID;
    assign entry       = '{data: MEM_RDATA, pc: tag};

    assign MEM_RDEN = issue;
    assign MEM_ADDR = PC_COUNT;
    assign PC_WE    = RST_N && (REDIR_VALID || issue);
    assign PC_DIN   = !PC_WE ? '0 : REDIR_VALID ? (REDIR_ADDR & ~32'd3) : PC_COUNT + ILEN;
    assign IR_VALID = !empty;
    assign IR_DATA  = head.data;
    assign IR_PC    = head.pc;

    always_comb begin
        state_n = REDIR_VALID ? ((outstanding && !MEM_RVALID) ? DISCARD : ISSUE) :
                  issue ? WAIT :
                  (outstanding && MEM_RVALID) ? ISSUE : state;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ISSUE;
            tag   <= '0;
        end else begin
            state <= state_n;
            if (issue) tag <= PC_COUNT;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (REDIR_VALID),
        .push  (push),
        .pop   (IR_READY),
        .din   (entry),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios for instr_fetch, checked every cycle against a
// queue-based model of the fetch rules plus hand-computed address sequences.
module tb_instr_fetch;
    import otter_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0, RST_N = 1'b0;
    logic [31:0] PC_COUNT = '0, PC_DIN, MEM_ADDR, MEM_RDATA = '0, REDIR_ADDR = '0, IR_DATA, IR_PC;
    logic        PC_WE, MEM_RDEN, MEM_RVALID = 1'b0, REDIR_VALID = 1'b0, IR_VALID, IR_READY = 1'b0;

    always #5 CLK = ~CLK;

    instr_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .PC_COUNT(PC_COUNT), .PC_WE(PC_WE), .PC_DIN(PC_DIN),
        .MEM_RDEN(MEM_RDEN), .MEM_ADDR(MEM_ADDR), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
        .REDIR_VALID(REDIR_VALID), .REDIR_ADDR(REDIR_ADDR), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
        .IR_DATA(IR_DATA), .IR_PC(IR_PC)
    );

    typedef struct {int due; logic [31:0] addr;} req_t;

    req_t         pend[$];
    fetch_entry_t q[$];
    logic [31:0]  req_log[$], irpc_log[$], din_log[$];
    logic [31:0]  pc_reg = '0, mtag = '0, old_addr;
    logic         busy = 1'b0, drop = 1'b0;
    int           cyc = 0, lat = 1, checks = 0, errors = 0, n, due_at;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic clear_logs();
        req_log.delete();
        irpc_log.delete();
        din_log.delete();
    endtask

    task automatic reset_zeros(input string tagname);
        chk({tagname, "_pc_we"}, PC_WE, 0);
        chk({tagname, "_pc_din"}, PC_DIN, 0);
        chk({tagname, "_mem_rden"}, MEM_RDEN, 0);
        chk({tagname, "_ir_valid"}, IR_VALID, 0);
        chk({tagname, "_ir_data"}, IR_DATA, 0);
        chk({tagname, "_ir_pc"}, IR_PC, 0);
    endtask

    // One clock: drive inputs just after the edge, compare at the falling edge, then
    // advance the model, the memory responder and the PC register together.
    task automatic cycle(input logic redir = 1'b0, input logic [31:0] raddr = '0, input logic ready = 1'b1);
        logic        rv, iss, we, fire;
        logic [31:0] rdata, din;
        rv    = pend.size() > 0 && pend[0].due == cyc;
        rdata = rv ? word(pend[0].addr) : '0;
        if (rv) void'(pend.pop_front());
        PC_COUNT    = pc_reg;
        REDIR_VALID = redir;
        REDIR_ADDR  = raddr;
        IR_READY    = ready;
        MEM_RVALID  = rv;
        MEM_RDATA   = rdata;
        @(negedge CLK);
        we  = PC_WE;
        din = PC_DIN;
        if (MEM_RDEN) pend.push_back('{cyc + lat, MEM_ADDR});
        if (!RST_N) begin
            chk("rst_mem_rden", MEM_RDEN, 0);
            chk("rst_pc_we", PC_WE, 0);
            chk("rst_ir_valid", IR_VALID, 0);
            q.delete();
            busy = 1'b0;
            drop = 1'b0;
        end else begin
            iss  = !redir && !busy && q.size() < DEPTH;
            fire = q.size() > 0 && ready;
            chk("mem_rden", MEM_RDEN, iss);
            chk("pc_we", PC_WE, redir || iss);
            if (redir) chk("pc_din_redir", PC_DIN, raddr & ~32'd3);
            else if (iss) chk("pc_din_seq", PC_DIN, pc_reg + 32'd4);
            if (iss) chk("mem_addr", MEM_ADDR, pc_reg);
            chk("ir_valid", IR_VALID, q.size() > 0);
            if (q.size() > 0) begin
                chk("ir_data", IR_DATA, q[0].data);
                chk("ir_pc", IR_PC, q[0].pc);
            end
            if (iss) req_log.push_back(pc_reg);
            if (redir || iss) din_log.push_back(redir ? (raddr & ~32'd3) : pc_reg + 32'd4);
            if (fire) irpc_log.push_back(q[0].pc);
            if (fire) void'(q.pop_front());
            if (redir) begin
                q.delete();
                drop = busy && !rv;
                busy = busy && !rv;
            end else begin
                if (busy && rv) begin
                    if (!drop) q.push_back('{data: rdata, pc: mtag});
                    busy = 1'b0;
                    drop = 1'b0;
                end
                if (iss) begin
                    busy = 1'b1;
                    mtag = pc_reg;
                end
            end
        end
        @(posedge CLK);
        #1;
        if (we) pc_reg = din;
        cyc++;
    endtask

    initial begin
        #1;
        reset_zeros("por");
        @(posedge CLK);
        #1;
        repeat (2) cycle();
        RST_N = 1'b1;

        // Sequential fetch, memory latency 1, decode always ready.
        clear_logs();
        lat = 1;
        repeat (7) cycle();
        chk("s1_nreq", req_log.size(), 4);
        chk("s1_req0", req_log[0], 32'h0);
        chk("s1_req1", req_log[1], 32'h4);
        chk("s1_req2", req_log[2], 32'h8);
        chk("s1_nir", irpc_log.size(), 3);
        chk("s1_ir0", irpc_log[0], 32'h0);
        chk("s1_ir1", irpc_log[1], 32'h4);
        chk("s1_ir2", irpc_log[2], 32'h8);
        chk("s1_din0", din_log[0], 32'h4);
        chk("s1_din1", din_log[1], 32'h8);
        chk("s1_din2", din_log[2], 32'hC);

        // Decode stalls: buffer fills, requests stop, then drain in order.
        clear_logs();
        repeat (6) cycle(1'b0, '0, 1'b0);
        chk("s2_nreq_stall", req_log.size(), 1);
        chk("s2_req_stall", req_log[0], 32'h10);
        chk("s2_nir_stall", irpc_log.size(), 0);
        clear_logs();
        repeat (3) cycle();
        chk("s2_nir_drain", irpc_log.size(), 2);
        chk("s2_ir0", irpc_log[0], 32'hC);
        chk("s2_ir1", irpc_log[1], 32'h10);
        chk("s2_resume", req_log[0], 32'h14);

        // Redirect while waiting on a slow response.
        lat = 3;
        cycle();
        clear_logs();
        cycle(1'b1, 32'h100, 1'b1);
        repeat (8) cycle();
        chk("s3_din_redir", din_log[0], 32'h100);
        chk("s3_req0", req_log[0], 32'h100);
        chk("s3_nir", irpc_log.size(), 1);
        chk("s3_ir0", irpc_log[0], 32'h100);

        // Redirect in the same cycle as the response.
        lat = 2;
        n = 0;
        while (!(pend.size() > 0 && pend[0].due == cyc) && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) expire("s4_wait_resp");
        clear_logs();
        cycle(1'b1, 32'h300, 1'b1);
        cycle();
        chk("s4_nreq_next", req_log.size(), 1);
        chk("s4_req_next", req_log[0], 32'h300);
        repeat (4) cycle();
        chk("s4_nir", irpc_log.size(), 1);
        chk("s4_ir0", irpc_log[0], 32'h300);

        // PC wrap and word alignment of redirect targets.
        clear_logs();
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
        repeat (6) cycle();
        chk("s5_din_top", din_log[0], 32'hFFFF_FFFC);
        chk("s5_din_wrap", din_log[1], 32'h0);
        chk("s5_ir_top", irpc_log[0], 32'hFFFF_FFFC);
        clear_logs();
        cycle(1'b1, 32'h203, 1'b1);
        repeat (6) cycle();
        chk("s5_din_align", din_log[0], 32'h200);
        chk("s5_req_align", req_log[0], 32'h200);

        // Reset with one buffered word and a request in flight; its late response
        // lands on the first cycle after release and must be ignored.
        lat = 3;
        n = 0;
        while (!(q.size() == 1 && busy) && n < 30) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        if (n >= 30) expire("s6_setup");
        old_addr = pend.size() > 0 ? pend[0].addr : '0;
        due_at   = pend.size() > 0 ? pend[0].due : cyc;
        RST_N = 1'b0;
        #1;
        reset_zeros("s6_async");
        n = 0;
        while (cyc < due_at && n < 10) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        RST_N = 1'b1;
        clear_logs();
        repeat (6) cycle();
        chk("s6_req0", req_log[0], old_addr + 32'd4);
        chk("s6_nir", irpc_log.size(), 1);
        chk("s6_ir0", irpc_log[0], old_addr + 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
